int_src_latch: RTL and testbench

- Interrupt source conditioning stage directly upstream of the interrupt controller.
- Takes 8 raw peripheral interrupt lines (SYSCALL, SYSTICK, SPI, UART, I2C, PORT, TIM, XINT). Conditions each one per source: polarity, edge or level detection, sticky pending latch, software trigger.
- Drives the controller's 8-bit INT_ARR input.
- Software programs and services it over the same 8-bit Wishbone slave bus used by the rest of the peripheral set.

---
 rtl/int_src_latch_pkg.sv | 20 ++
 rtl/int_src_latch_if.sv | 12 +
 rtl/int_src_cell.sv | 45 ++++
 rtl/int_src_latch.sv | 66 ++++++
 tb/tb_int_src_latch.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/int_src_latch_pkg.sv
// int_src_latch_pkg: shared constants and types for the interrupt source conditioning stage
package int_src_latch_pkg;
    localparam int NSRC = 8;
    typedef logic [NSRC-1:0] src_vec_t;
    typedef enum logic [2:0] {
        ADR_PEND   = 3'd0,
        ADR_MODE   = 3'd1,
        ADR_POL    = 3'd2,
        ADR_SWTRIG = 3'd3,
        ADR_OVF    = 3'd4
    } reg_adr_e;
    localparam int SYSCALL = 7;
    localparam int SYSTICK = 6;
    localparam int SPI     = 5;
    localparam int UART    = 4;
    localparam int I2C     = 3;
    localparam int PORT    = 2;
    localparam int TIM     = 1;
    localparam int XINT    = 0;
endpackage

// File: rtl/int_src_latch_if.sv
// int_src_latch_if: 8-bit Wishbone slave register bus of the interrupt source stage
interface int_src_latch_if;
    logic [2:0] WB_ADRi;
    logic [7:0] WB_DATi;
    logic [7:0] WB_DATo;
    logic       WB_WEi;
    logic       WB_CYCi;
    logic       WB_STBi;
    logic       WB_ACKo;
    modport slave (input WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi, output WB_DATo, WB_ACKo);
    modport master (output WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi, input WB_DATo, WB_ACKo);
endinterface

// File: rtl/int_src_cell.sv
// int_src_cell: one interrupt source slice (optional sync, edge history, pending and overflow latches).
// INT_SRC_LATCH_SYNC_EN adds a 2-flop synchronizer in front of the detector.
module int_src_cell (
    input  logic clk,
    input  logic rst,
    input  logic src_i,
    input  logic mode_i,
    input  logic pol_i,
    input  logic mode_chg_i,
    input  logic sw_set_i,
    input  logic pend_clr_i,
    input  logic ovf_clr_i,
    output logic pend_o,
    output logic ovf_o
);
    logic s, hist_q, pend_q, pend_d, ovf_q, ovf_d, evt, set_c, ovf_set;
`ifdef INT_SRC_LATCH_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk) sync_q <= rst ? 2'b00 : {sync_q[0], src_i};
    assign s = sync_q[1];
`else
    assign s = src_i;
`endif
    // history holds the raw sample so a polarity change alone never looks like an edge
    assign evt   = pol_i ? (hist_q & ~s) : (~hist_q & s);
    assign set_c = evt | sw_set_i;
    always_comb begin
        pend_d  = mode_chg_i ? 1'b0 : !mode_i ? s ^ pol_i : set_c ? 1'b1 : pend_clr_i ? 1'b0 : pend_q;
        ovf_set = mode_i & ~mode_chg_i & set_c & pend_q & ~pend_clr_i;
        ovf_d   = ovf_set ? 1'b1 : ovf_clr_i ? 1'b0 : ovf_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 1'b0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            hist_q <= s;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end
    assign pend_o = pend_q;
    assign ovf_o  = ovf_q;
endmodule

// File: rtl/int_src_latch.sv
// int_src_latch: per-source interrupt conditioning with Wishbone register access, feeding INT_ARR.
// INT_SRC_LATCH_SYNC_EN synchronizes SRC_IRQ inside each cell (2 extra cycles of latency).
module int_src_latch
    import int_src_latch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  src_vec_t          SRC_IRQ,
    output src_vec_t          INT_ARR,
    int_src_latch_if.slave    wb
);
    logic     ack_q, acc, wr;
    logic [7:0] dat_q, rd_data;
    src_vec_t mode_q, mode_d, pol_q, pol_d, pend, ovf, mode_chg, sw_set, pend_clr, ovf_clr;

    // an access is taken only while no ack is outstanding, giving two cycles per access
    assign acc = wb.WB_CYCi & wb.WB_STBi & ~ack_q;
    assign wr  = acc & wb.WB_WEi;

    always_comb begin
        rd_data  = wb.WB_ADRi == ADR_PEND ? pend :
                   wb.WB_ADRi == ADR_MODE ? mode_q :
                   wb.WB_ADRi == ADR_POL  ? pol_q :
                   wb.WB_ADRi == ADR_OVF  ? ovf : 8'h00;
        mode_d   = (wr && wb.WB_ADRi == ADR_MODE) ? wb.WB_DATi : mode_q;
        pol_d    = (wr && wb.WB_ADRi == ADR_POL) ? wb.WB_DATi : pol_q;
        mode_chg = mode_d ^ mode_q;
        sw_set   = (wr && wb.WB_ADRi == ADR_SWTRIG) ? wb.WB_DATi : '0;
        pend_clr = (wr && wb.WB_ADRi == ADR_PEND) ? wb.WB_DATi : '0;
        ovf_clr  = (wr && wb.WB_ADRi == ADR_OVF) ? wb.WB_DATi : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q  <= 1'b0;
            dat_q  <= 8'h00;
            mode_q <= '0;
            pol_q  <= '0;
        end else begin
            ack_q  <= acc;
            dat_q  <= acc ? rd_data : dat_q;
            mode_q <= mode_d;
            pol_q  <= pol_d;
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_cell
        int_src_cell u_cell (
            .clk        (clk),
            .rst        (rst),
            .src_i      (SRC_IRQ[i]),
            .mode_i     (mode_q[i]),
            .pol_i      (pol_q[i]),
            .mode_chg_i (mode_chg[i]),
            .sw_set_i   (sw_set[i]),
            .pend_clr_i (pend_clr[i]),
            .ovf_clr_i  (ovf_clr[i]),
            .pend_o     (pend[i]),
            .ovf_o      (ovf[i])
        );
    end

    assign INT_ARR    = pend;
    assign wb.WB_DATo = dat_q;
    assign wb.WB_ACKo = ack_q;
endmodule

// File: tb/tb_int_src_latch.sv
// tb_int_src_latch: directed plus random stimulus against a per-cycle behavioural register model
module tb_int_src_latch;
    import int_src_latch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] SRC_IRQ = 8'h00;
    logic [7:0] INT_ARR;
    int n_chk = 0;
    int n_err = 0;

    int_src_latch_if wb ();

    int_src_latch dut (
        .clk     (clk),
        .rst     (rst),
        .SRC_IRQ (SRC_IRQ),
        .INT_ARR (INT_ARR),
        .wb      (wb)
    );

    always #5 clk = ~clk;

    // reference state, updated once per rising edge from the documented register rules
    logic [7:0] m_pend = 0, m_mode = 0, m_pol = 0, m_ovf = 0, m_hist = 0, m_dat = 0;
    logic [7:0] m_s1 = 0, m_s2 = 0;
    logic       m_ack = 0;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [7:0] s, rd, nmode, npol, npend, novf;
        logic acc, wr, evt, setc, clrc;
        if (rst) begin
            {m_pend, m_mode, m_pol, m_ovf, m_hist, m_dat, m_s1, m_s2} = '0;
            m_ack = 1'b0;
            return;
        end
`ifdef INT_SRC_LATCH_SYNC_EN
        s = m_s2;
        m_s2 = m_s1;
        m_s1 = SRC_IRQ;
`else
        s = SRC_IRQ;
`endif
        acc = wb.WB_CYCi && wb.WB_STBi && !m_ack;
        wr = acc && wb.WB_WEi;
        case (wb.WB_ADRi)
            3'd0: rd = m_pend;
            3'd1: rd = m_mode;
            3'd2: rd = m_pol;
            3'd4: rd = m_ovf;
            default: rd = 8'h00;
        endcase
        nmode = (wr && wb.WB_ADRi == 3'd1) ? wb.WB_DATi : m_mode;
        npol = (wr && wb.WB_ADRi == 3'd2) ? wb.WB_DATi : m_pol;
        for (int i = 0; i < 8; i++) begin
            evt = m_pol[i] ? (m_hist[i] && !s[i]) : (!m_hist[i] && s[i]);
            setc = evt || (wr && wb.WB_ADRi == 3'd3 && wb.WB_DATi[i]);
            clrc = wr && wb.WB_ADRi == 3'd0 && wb.WB_DATi[i];
            npend[i] = m_pend[i];
            novf[i] = m_ovf[i];
            if (wr && wb.WB_ADRi == 3'd4 && wb.WB_DATi[i]) novf[i] = 1'b0;
            if (nmode[i] != m_mode[i]) npend[i] = 1'b0;
            else if (!m_mode[i]) npend[i] = s[i] ^ m_pol[i];
            else if (setc) begin
                if (m_pend[i] && !clrc) novf[i] = 1'b1;
                npend[i] = 1'b1;
            end else if (clrc) npend[i] = 1'b0;
        end
        if (acc) m_dat = rd;
        m_ack = acc;
        m_pend = npend;
        m_ovf = novf;
        m_mode = nmode;
        m_pol = npol;
        m_hist = s;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("int_arr", INT_ARR, m_pend);
        chk("ack", {7'b0, wb.WB_ACKo}, {7'b0, m_ack});
        chk("dat_o", wb.WB_DATo, m_dat);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wb_xfer(input logic we, input logic [2:0] adr, input logic [7:0] dat, output logic [7:0] rdat);
        wb.WB_CYCi = 1'b1;
        wb.WB_STBi = 1'b1;
        wb.WB_WEi = we;
        wb.WB_ADRi = adr;
        wb.WB_DATi = dat;
        step();
        rdat = wb.WB_DATo;
        chk("ack_pulse", {7'b0, wb.WB_ACKo}, 8'h01);
        wb.WB_CYCi = 1'b0;
        wb.WB_STBi = 1'b0;
        step();
        chk("ack_drop", {7'b0, wb.WB_ACKo}, 8'h00);
    endtask

    task automatic wr(input logic [2:0] adr, input logic [7:0] dat);
        logic [7:0] d;
        wb_xfer(1'b1, adr, dat, d);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] adr, input logic [7:0] exp);
        logic [7:0] d;
        wb_xfer(1'b0, adr, 8'h00, d);
        chk(tag, d, exp);
    endtask

    initial begin
        wb.WB_CYCi = 0; wb.WB_STBi = 0; wb.WB_WEi = 0; wb.WB_ADRi = 0; wb.WB_DATi = 0;
        @(negedge clk);
        steps(2);
        rst = 1'b0;
        chk("reset_int_arr", INT_ARR, 8'h00);
        for (int a = 0; a < 8; a++) rd_chk("reset_read", 3'(a), 8'h00);

        // edge mode rising pulse latches until cleared
        wr(ADR_MODE, 8'h01);
        wr(ADR_POL, 8'h00);
        SRC_IRQ[XINT] = 1'b1;
        step();
        SRC_IRQ[XINT] = 1'b0;
        steps(4);
        chk("edge_latch", INT_ARR, 8'h01);
        wr(ADR_PEND, 8'h01);
        steps(1);
        chk("edge_w1c", INT_ARR, 8'h00);

        // falling edges twice without a clear produce overflow
        wr(ADR_MODE, 8'h02);
        wr(ADR_POL, 8'h02);
        for (int k = 0; k < 2; k++) begin
            SRC_IRQ[TIM] = 1'b1;
            steps(3);
            SRC_IRQ[TIM] = 1'b0;
            steps(3);
        end
        rd_chk("ovf_pend", ADR_PEND, 8'h02);
        rd_chk("ovf_set", ADR_OVF, 8'h02);
        wr(ADR_OVF, 8'h02);
        rd_chk("ovf_clr", ADR_OVF, 8'h00);

        // active-low level source ignores W1C while active
        wr(ADR_MODE, 8'h00);
        wr(ADR_POL, 8'h80);
        steps(3);
        chk("level_low_active", INT_ARR, 8'h80);
        SRC_IRQ[SYSCALL] = 1'b1;
        steps(3);
        chk("level_low_idle", INT_ARR, 8'h00);
        SRC_IRQ[SYSCALL] = 1'b0;
        steps(3);
        wr(ADR_PEND, 8'h80);
        chk("level_ignores_w1c", INT_ARR, 8'h80);

        // software trigger only reaches edge-mode bits
        wr(ADR_POL, 8'h00);
        wr(ADR_MODE, 8'h04);
        wr(ADR_SWTRIG, 8'h05);
        rd_chk("swtrig_pend", ADR_PEND, 8'h04);
        rd_chk("swtrig_read", ADR_SWTRIG, 8'h00);

        // edge coinciding with W1C keeps the bit set; POL toggle on steady input is no event
        wr(ADR_PEND, 8'h04);
        chk("pend_cleared", INT_ARR, 8'h00);
        SRC_IRQ[PORT] = 1'b1;
        wr(ADR_PEND, 8'h04);
        steps(3);
        chk("set_beats_clr", INT_ARR, 8'h04);
        wr(ADR_PEND, 8'h04);
        steps(3);
        wr(ADR_POL, 8'h04);
        steps(3);
        chk("pol_no_event", INT_ARR, 8'h00);
        wr(ADR_POL, 8'h00);
        steps(3);
        chk("pol_back_no_event", INT_ARR, 8'h00);

        // reset during an access drops the write
        wb.WB_CYCi = 1; wb.WB_STBi = 1; wb.WB_WEi = 1; wb.WB_ADRi = ADR_MODE; wb.WB_DATi = 8'hFF;
        rst = 1'b1;
        step();
        chk("rst_ack", {7'b0, wb.WB_ACKo}, 8'h00);
        rst = 1'b0;
        wb.WB_CYCi = 0; wb.WB_STBi = 0;
        step();
        rd_chk("rst_drop_write", ADR_MODE, 8'h00);

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 2) == 0) SRC_IRQ[$urandom_range(0, 7)] ^= 1'b1;
            wb.WB_CYCi = ($urandom_range(0, 3) != 0);
            wb.WB_STBi = ($urandom_range(0, 3) != 0);
            wb.WB_WEi = $urandom_range(0, 1);
            wb.WB_ADRi = 3'($urandom_range(0, 7));
            wb.WB_DATi = 8'($urandom);
            step();
        end
        rst = 1'b0;
        wb.WB_CYCi = 0; wb.WB_STBi = 0;
        steps(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
